// File: rtl/rotor_stack.sv
// Enigma I scrambler: rotors I/II/III (left/middle/right), reflector B, ring settings A.
// One letter per IDLE->STEP->SCRAMBLE->HOLD pass; rotors step before the letter is enciphered.
module rotor_stack #(
  parameter logic [4:0] NOTCH_L = 5'd16,
  parameter logic [4:0] NOTCH_M = 5'd4,
  parameter logic [4:0] NOTCH_R = 5'd21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_pos,
  input  logic [4:0] pos_l_in,
  input  logic [4:0] pos_m_in,
  input  logic [4:0] pos_r_in,
  input  logic       in_valid,
  input  logic [4:0] in_letter,
  output logic       in_ready,
  output logic       out_valid,
  output logic [4:0] out_letter,
  input  logic       out_ready,
  output logic       err,
  output logic [4:0] pos_l,
  output logic [4:0] pos_m,
  output logic [4:0] pos_r
);

  if (NOTCH_L > 5'd25 || NOTCH_M > 5'd25 || NOTCH_R > 5'd25) begin : g_notch_check
    $error("rotor_stack: notch parameter outside 0-25");
  end

  typedef enum logic [1:0] {IDLE, STEP, SCRAMBLE, HOLD} state_t;

  // Wiring as ASCII strings, entry 0 = contact A; inverses are precomputed constants.
  localparam logic [0:25][7:0] ROT_I   = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
  localparam logic [0:25][7:0] ROT_II  = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
  localparam logic [0:25][7:0] ROT_III = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
  localparam logic [0:25][7:0] REF_B   = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
  localparam logic [0:25][7:0] INV_I   = "UWYGADFPVZBECKMTHXSLRINQOJ";
  localparam logic [0:25][7:0] INV_II  = "AJPCZWRLFBDKOTYUQGENHXMIVS";
  localparam logic [0:25][7:0] INV_III = "TAGBPCSDQEUFVNZHYIXJWLRKOM";

  function automatic logic [4:0] wire_map(input logic [0:25][7:0] tbl, input logic [4:0] idx);
    return 5'(tbl[idx] - 8'd65);
  endfunction

  function automatic logic [4:0] add26(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 6'd26) s = s - 6'd26;
    return s[4:0];
  endfunction

  function automatic logic [4:0] sub26(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[5]) d = d + 6'd26;
    return d[4:0];
  endfunction

  function automatic logic [4:0] rotor(input logic [0:25][7:0] tbl, input logic [4:0] x,
                                       input logic [4:0] p);
    return sub26(wire_map(tbl, add26(x, p)), p);
  endfunction

  function automatic logic [4:0] inc26(input logic [4:0] p);
    return (p == 5'd25) ? '0 : p + 5'd1;
  endfunction

  function automatic logic [4:0] clamp26(input logic [4:0] p);
    return (p > 5'd25) ? '0 : p;
  endfunction

  state_t     state, state_nx;
  logic [4:0] letter;
  logic [4:0] s_r, s_m, s_l, s_refl, s_li, s_mi, scrambled;
  logic       step_m, step_l;

  assign s_r       = rotor(ROT_III, letter, pos_r);
  assign s_m       = rotor(ROT_II,  s_r,    pos_m);
  assign s_l       = rotor(ROT_I,   s_m,    pos_l);
  assign s_refl    = wire_map(REF_B, s_l);
  assign s_li      = rotor(INV_I,   s_refl, pos_l);
  assign s_mi      = rotor(INV_II,  s_li,   pos_m);
  assign scrambled = rotor(INV_III, s_mi,   pos_r);

  // Middle steps once whether driven by the right notch, its own notch, or both.
  assign step_l = (pos_m == NOTCH_M);
  assign step_m = (pos_r == NOTCH_R) || step_l;

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (!load_pos && in_valid && in_letter <= 5'd25) state_nx = STEP;
      end
      STEP:     state_nx = SCRAMBLE;
      SCRAMBLE: state_nx = HOLD;
      HOLD:     if (out_ready) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pos_l      <= '0;
      pos_m      <= '0;
      pos_r      <= '0;
      letter     <= '0;
      out_valid  <= 1'b0;
      out_letter <= '0;
      err        <= 1'b0;
    end else begin
      state <= state_nx;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (load_pos) begin
            pos_l <= clamp26(pos_l_in);
            pos_m <= clamp26(pos_m_in);
            pos_r <= clamp26(pos_r_in);
          end else if (in_valid) begin
            if (in_letter <= 5'd25) letter <= in_letter;
            else                    err    <= 1'b1;
          end
        end
        STEP: begin
          pos_r <= inc26(pos_r);
          if (step_m) pos_m <= inc26(pos_m);
          if (step_l) pos_l <= inc26(pos_l);
        end
        SCRAMBLE: begin
          out_letter <= scrambled;
          out_valid  <= 1'b1;
        end
        HOLD: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rotor_stack.sv
// Directed bench for rotor_stack: known Enigma I vectors, double step, errors, hold and reset.
module tb_rotor_stack;
  logic       clk = 1'b0;
  logic       rst, load_pos, in_valid, out_ready;
  logic [4:0] pos_l_in, pos_m_in, pos_r_in, in_letter;
  logic       in_ready, out_valid, err;
  logic [4:0] out_letter, pos_l, pos_m, pos_r;

  int n_cmp = 0;
  int n_bad = 0;

  rotor_stack #(.NOTCH_L(5'd16), .NOTCH_M(5'd4), .NOTCH_R(5'd21)) dut (
    .clk(clk), .rst(rst), .load_pos(load_pos),
    .pos_l_in(pos_l_in), .pos_m_in(pos_m_in), .pos_r_in(pos_r_in),
    .in_valid(in_valid), .in_letter(in_letter), .in_ready(in_ready),
    .out_valid(out_valid), .out_letter(out_letter), .out_ready(out_ready),
    .err(err), .pos_l(pos_l), .pos_m(pos_m), .pos_r(pos_r)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [4:0] l, input logic [4:0] m, input logic [4:0] r);
    load_pos = 1'b1; pos_l_in = l; pos_m_in = m; pos_r_in = r;
    tick;
    load_pos = 1'b0;
  endtask

  // Drives one letter through and returns it plus edges from accept to out_valid.
  task automatic send(input logic [4:0] x, output logic [4:0] y, output int lat);
    in_valid = 1'b1; in_letter = x;
    tick;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 10) begin tick; lat++; end
    y = out_letter;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; load_pos = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    pos_l_in = '0; pos_m_in = '0; pos_r_in = '0; in_letter = '0;
    #3;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out_letter !== 5'd0) begin n_bad++; $display("FAIL reset_out_letter: got %0d expected 0", out_letter); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", err); end
    n_cmp++; if ({pos_l, pos_m, pos_r} !== 15'd0) begin n_bad++; $display("FAIL reset_pos: got %0d/%0d/%0d expected 0/0/0", pos_l, pos_m, pos_r); end
    tick; tick;
    rst = 1'b0;
    tick;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_known_sequence;
    logic [4:0] exp_out [5] = '{5'd1, 5'd3, 5'd25, 5'd6, 5'd14};
    logic [4:0] y;
    int lat;
    load(5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 5; i++) begin
      send(5'd0, y, lat);
      n_cmp++; if (y !== exp_out[i]) begin n_bad++; $display("FAIL seq_letter%0d: got %0d expected %0d", i, y, exp_out[i]); end
      n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL seq_latency%0d: got %0d expected 2", i, lat); end
    end
    n_cmp++; if ({pos_l, pos_m, pos_r} !== {5'd0, 5'd0, 5'd5}) begin n_bad++; $display("FAIL seq_pos: got %0d/%0d/%0d expected 0/0/5", pos_l, pos_m, pos_r); end
  endtask

  task automatic test_double_step;
    logic [14:0] exp_pos [3] = '{{5'd0, 5'd3, 5'd21}, {5'd0, 5'd4, 5'd22}, {5'd1, 5'd5, 5'd23}};
    logic [4:0] y;
    int lat;
    load(5'd0, 5'd3, 5'd20);
    for (int i = 0; i < 3; i++) begin
      send(5'd0, y, lat);
      n_cmp++; if ({pos_l, pos_m, pos_r} !== exp_pos[i]) begin n_bad++; $display("FAIL dstep_pos%0d: got %0d/%0d/%0d expected %0d/%0d/%0d", i, pos_l, pos_m, pos_r, exp_pos[i][14:10], exp_pos[i][9:5], exp_pos[i][4:0]); end
    end
  endtask

  task automatic test_reciprocal;
    logic [4:0] cipher [5] = '{5'd1, 5'd3, 5'd25, 5'd6, 5'd14};
    logic [4:0] y;
    int lat;
    load(5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 5; i++) begin
      send(cipher[i], y, lat);
      n_cmp++; if (y !== 5'd0) begin n_bad++; $display("FAIL recip_letter%0d: got %0d expected 0", i, y); end
    end
  endtask

  task automatic test_bad_letter;
    logic [14:0] p0;
    load(5'd2, 5'd7, 5'd11);
    p0 = {pos_l, pos_m, pos_r};
    in_valid = 1'b1; in_letter = 5'd27;
    tick;
    in_valid = 1'b0;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL bad_err_pulse: got %b expected 1", err); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bad_in_ready: got %b expected 1", in_ready); end
    tick;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL bad_err_clear: got %b expected 0", err); end
    tick; tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bad_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if ({pos_l, pos_m, pos_r} !== p0) begin n_bad++; $display("FAIL bad_pos: got %0d/%0d/%0d expected 2/7/11", pos_l, pos_m, pos_r); end
    // load_pos wins over a simultaneous letter; out-of-range positions load as 0
    load_pos = 1'b1; pos_l_in = 5'd30; pos_m_in = 5'd2; pos_r_in = 5'd26;
    in_valid = 1'b1; in_letter = 5'd5;
    tick;
    load_pos = 1'b0; in_valid = 1'b0;
    tick; tick; tick;
    n_cmp++; if ({pos_l, pos_m, pos_r} !== {5'd0, 5'd2, 5'd0}) begin n_bad++; $display("FAIL load_clamp_pos: got %0d/%0d/%0d expected 0/2/0", pos_l, pos_m, pos_r); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL load_prio_out_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_hold;
    int waited;
    load(5'd0, 5'd0, 5'd0);
    in_valid = 1'b1; in_letter = 5'd0;
    tick;
    in_valid = 1'b0;
    waited = 0;
    while (!out_valid && waited < 10) begin tick; waited++; end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL hold_arrive: got %b expected 1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      load_pos = 1'b1; pos_l_in = 5'd7; pos_m_in = 5'd7; pos_r_in = 5'd7;
      tick;
      n_cmp++; if (out_letter !== 5'd1 || out_valid !== 1'b1) begin n_bad++; $display("FAIL hold_stable%0d: got %0d/%b expected 1/1", i, out_letter, out_valid); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL hold_in_ready%0d: got %b expected 0", i, in_ready); end
    end
    load_pos = 1'b0;
    n_cmp++; if ({pos_l, pos_m, pos_r} !== {5'd0, 5'd0, 5'd1}) begin n_bad++; $display("FAIL hold_load_ignored: got %0d/%0d/%0d expected 0/0/1", pos_l, pos_m, pos_r); end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL hold_release: got valid=%b ready=%b expected 0/1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid;
    logic [4:0] y;
    int lat;
    load(5'd0, 5'd0, 5'd0);
    in_valid = 1'b1; in_letter = 5'd0;
    tick;
    in_valid = 1'b0;
    tick;
    rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if ({pos_l, pos_m, pos_r} !== 15'd0) begin n_bad++; $display("FAIL rstmid_pos: got %0d/%0d/%0d expected 0/0/0", pos_l, pos_m, pos_r); end
    tick;
    rst = 1'b0;
    tick; tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_output: got %b expected 0", out_valid); end
    send(5'd0, y, lat);
    n_cmp++; if (y !== 5'd1) begin n_bad++; $display("FAIL rstmid_next_letter: got %0d expected 1", y); end
  endtask

  initial begin
    test_reset;
    test_known_sequence;
    test_double_step;
    test_reciprocal;
    test_bad_letter;
    test_hold;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
